mem_stage_lsu: RTL and testbench
================================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (async active-low reset).
REQ-002 The EX/MEM-side inputs SHALL be: regWrite_M, memWrite_M, memRead_M, resultScr_M input 1 each (control); alu_rsl_M input 32 (address / ALU result); write_Data_M input 32 (store data); rd_M input 5; mode_M input 3 (funct3 access mode).
REQ-003 The data-memory port SHALL be: dmem_req output 1; dmem_we output 1; dmem_addr output 32 (word-aligned, [1:0]=0); dmem_be output 4; dmem_wdata output 32; dmem_ack input 1; dmem_rdata input 32.
REQ-004 The MEM/WB-side outputs SHALL be: regWrite_W, resultScr_W output 1 each; alu_rsl_W output 32; read_data_W output 32 (aligned, extended load data); rd_W output 5.
REQ-005 The hazard-side outputs SHALL be: stall_M output 1 (freeze PC, IF/ID, ID/EX, EX/MEM); fault_M output 1 (one-cycle misalign/illegal-mode pulse).

Function
REQ-006 Mode decode SHALL be: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; every other mode is illegal for that access type.
REQ-007 Fault SHALL be: illegal mode, or word access with addr[1:0]!=0, or half access with addr[0]!=0; memRead_M and memWrite_M both high is also a fault.
REQ-008 The FSM SHALL have the states IDLE, REQ and DONE.
REQ-009 In IDLE with no access, stall_M SHALL be 0.
REQ-010 In IDLE with a fault, the block SHALL make no request, pulse fault_M for 1 cycle, keep stall_M=0, and force regWrite_W=0 for that instruction.
REQ-011 In IDLE with a valid access, the block SHALL assert stall_M combinationally and move to REQ on the next edge.
REQ-012 In REQ, dmem_req SHALL be 1 and stall_M SHALL be 1; dmem_we, dmem_addr, dmem_be and dmem_wdata SHALL be registered at entry and held stable until the ack.
REQ-013 When dmem_ack=1 in REQ, the block SHALL capture the formatted load data into an internal buffer, drop dmem_req on the next edge, and go to DONE.
REQ-014 In DONE, stall_M SHALL be 0 for exactly 1 cycle, MEM/WB SHALL capture the instruction, and the FSM SHALL return to IDLE without re-triggering on the still-present inputs.
REQ-015 dmem_ack outside REQ SHALL be ignored, and an ack held high across cycles SHALL count once.
REQ-016 Latency SHALL be: a non-memory instruction reaches MEM/WB 1 edge after arrival; a memory access with zero-wait ack completes in 3 cycles (IDLE, REQ, DONE); each extra wait cycle adds 1.
REQ-017 Store alignment SHALL be: SB be=4'b0001<<addr[1:0], wdata={4{byte}}; SH be=addr[1]?1100:0011, wdata={2{half}}; SW be=1111; loads drive be=1111 and we=0.
REQ-018 Load format SHALL be: rdata>>(8*addr[1:0]), then LB/LH sign-extend and LBU/LHU zero-extend to 32 bits.
REQ-019 MEM/WB SHALL load a bubble (regWrite_W=0, rd_W=0, all other outputs 0) on every edge where stall_M=1, and SHALL load the current instruction otherwise.
REQ-020 read_data_W SHALL be the buffered load data for loads and 0 for non-loads.
REQ-021 Stores SHALL propagate regWrite_W as supplied, which is normally 0.

Reset
REQ-022 Asserting rst_n=0 SHALL immediately, asynchronously, set: FSM=IDLE; dmem_req=0; dmem_we=0; dmem_addr, dmem_be and dmem_wdata=0; all *_W outputs 0; load buffer 0; fault_M=0.
REQ-023 Reset in REQ SHALL abandon the request, and the memory SHALL tolerate a dropped request.
REQ-024 stall_M SHALL be 0 while in reset.
REQ-025 The first access after reset release SHALL behave exactly as from IDLE.

Structure
REQ-026 Mode encodings, the state encoding and the byte-enable constants SHALL live in the shared package/header mem_pkg, which the decoder and EX stage also use.
REQ-027 One combinational sub-module lsu_align SHALL hold store byte-lane steering, load extraction/extension and fault detection; the FSM and the MEM/WB register SHALL live in mem_stage_lsu.

Verification
REQ-028 The bench SHALL check: SW addr=0x100, data=0xDEADBEEF, ack on first REQ cycle -> req for 1 cycle, be=1111, addr=0x100, stall_M high 2 cycles, regWrite_W=0.
REQ-029 The bench SHALL check: SB addr=0x103, data=0x000000A5 -> be=1000, wdata=0xA5A5A5A5; LB from 0x103 with rdata=0x80FFFFFF -> read_data_W=0xFFFFFF80; LBU -> 0x00000080.
REQ-030 The bench SHALL check: LH addr=0x102, rdata=0x8001_1234, ack after 3 wait cycles -> stall_M high 5 cycles, read_data_W=0xFFFF8001, and exactly one non-bubble MEM/WB entry.
REQ-031 The bench SHALL check: LW addr=0x101 -> no dmem_req, fault_M 1-cycle pulse, regWrite_W=0, stall_M=0; mode 011 load -> same.
REQ-032 The bench SHALL check: rst_n dropped mid-REQ -> dmem_req=0 and all outputs 0 in the same cycle; after release, an ADD (regWrite=1, alu=0x2A, rd=5) -> regWrite_W=1, alu_rsl_W=0x2A, rd_W=5 one edge later.
REQ-033 The bench SHALL check: ack held high for 4 cycles on one load, then back-to-back LW -> exactly two requests, and the second load does not complete on the stale ack.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared load/store definitions: funct3 access modes, LSU state encoding,
// byte-enable constants and mode legality helpers.
package mem_pkg;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  function automatic logic is_load_mode(input logic [2:0] mode);
    case (mode)
      MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic is_store_mode(input logic [2:0] mode);
    case (mode)
      MODE_B, MODE_H, MODE_W: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath of the LSU: store lane steering, load extraction
// with sign/zero extension, and access fault detection.
module lsu_align
  import mem_pkg::*;
(
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        fault
);

  logic        misalign;
  logic [31:0] shifted;

  // Fault: conflicting controls, illegal mode for the access type, or misalignment.
  always_comb begin
    case (mode[1:0])
      2'b01:   misalign = addr[0];
      2'b10:   misalign = (addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
    fault = (mem_read & mem_write)
          | (mem_read  & (~is_load_mode(mode)  | misalign))
          | (mem_write & (~is_store_mode(mode) | misalign));
  end

  // Store lane steering; loads request the full word with no write data.
  always_comb begin
    be    = BE_ALL;
    wdata = '0;
    if (mem_write) begin
      case (mode)
        MODE_B: begin
          be    = BE_BYTE0 << addr[1:0];
          wdata = {4{store_data[7:0]}};
        end
        MODE_H: begin
          be    = addr[1] ? BE_HALF_HI : BE_HALF_LO;
          wdata = {2{store_data[15:0]}};
        end
        MODE_W:  wdata = store_data;
        default: wdata = '0;
      endcase
    end
  end

  // Load extraction: shift the addressed lane down, then extend.
  always_comb begin
    shifted = rdata >> {addr[1:0], 3'b000};
    case (mode)
      MODE_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      MODE_H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      MODE_W:  load_data = shifted;
      MODE_BU: load_data = {24'h0, shifted[7:0]};
      MODE_HU: load_data = {16'h0, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: sequences data-memory accesses, stalls the front of
// the pipe while a request is outstanding and owns the MEM/WB register.
//
// state | meaning
// IDLE  | no access in flight; non-memory instructions pass straight through
// REQ   | request outstanding on the memory port, waiting for a fresh ack
// DONE  | load data buffered; MEM/WB takes the instruction, pipe released
module mem_stage_lsu
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regWrite_M,
  input  logic        memWrite_M,
  input  logic        memRead_M,
  input  logic        resultScr_M,
  input  logic [31:0] alu_rsl_M,
  input  logic [31:0] write_Data_M,
  input  logic [4:0]  rd_M,
  input  logic [2:0]  mode_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        regWrite_W,
  output logic        resultScr_W,
  output logic [31:0] alu_rsl_W,
  output logic [31:0] read_data_W,
  output logic [4:0]  rd_W,
  output logic        stall_M,
  output logic        fault_M
);

  lsu_state_e  state, state_next;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_c, load_buf;
  logic        fault_c, ack_prev, ack_fresh, access;

  lsu_align u_align (
    .mem_read   (memRead_M),
    .mem_write  (memWrite_M),
    .mode       (mode_M),
    .addr       (alu_rsl_M),
    .store_data (write_Data_M),
    .rdata      (dmem_rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .load_data  (load_c),
    .fault      (fault_c)
  );

  assign access = memRead_M | memWrite_M;
  // An ack only counts on its rising edge, so a held ack completes one request.
  assign ack_fresh = dmem_ack & ~ack_prev;

  // Next-state, stall and fault pulse; both hazard outputs are quiet in reset.
  always_comb begin
    state_next = state;
    stall_M    = 1'b0;
    fault_M    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          if (fault_c) begin
            fault_M = 1'b1;
          end else begin
            stall_M    = 1'b1;
            state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_M = 1'b1;
        if (ack_fresh) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (!rst_n) begin
      stall_M = 1'b0;
      fault_M = 1'b0;
    end
  end

  // State register and ack edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ack_prev <= 1'b0;
    end else begin
      state    <= state_next;
      ack_prev <= dmem_ack;
    end
  end

  // Memory port: launched on REQ entry, held until the ack, then released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      load_buf   <= '0;
    end else if (state == ST_IDLE && state_next == ST_REQ) begin
      dmem_req   <= 1'b1;
      dmem_we    <= memWrite_M;
      dmem_addr  <= {alu_rsl_M[31:2], 2'b00};
      dmem_be    <= be_c;
      dmem_wdata <= wdata_c;
    end else if (state == ST_REQ && ack_fresh) begin
      dmem_req <= 1'b0;
      load_buf <= load_c;
    end
  end

  // MEM/WB register: bubble while stalled, otherwise take the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWrite_W  <= 1'b0;
      resultScr_W <= 1'b0;
      alu_rsl_W   <= '0;
      read_data_W <= '0;
      rd_W        <= '0;
    end else if (stall_M) begin
      regWrite_W  <= 1'b0;
      resultScr_W <= 1'b0;
      alu_rsl_W   <= '0;
      read_data_W <= '0;
      rd_W        <= '0;
    end else begin
      regWrite_W  <= regWrite_M & ~fault_c;
      resultScr_W <= resultScr_M;
      alu_rsl_W   <= alu_rsl_M;
      read_data_W <= (memRead_M & ~fault_c) ? load_buf : 32'h0;
      rd_W        <= rd_M;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed corner cases followed by
// random instructions, checked against an arithmetic reference model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        regWrite_M = 1'b0, memWrite_M = 1'b0, memRead_M = 1'b0, resultScr_M = 1'b0;
  logic [31:0] alu_rsl_M = '0, write_Data_M = '0;
  logic [4:0]  rd_M = '0;
  logic [2:0]  mode_M = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        regWrite_W, resultScr_W;
  logic [31:0] alu_rsl_W, read_data_W;
  logic [4:0]  rd_W;
  logic        stall_M, fault_M;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .regWrite_M(regWrite_M), .memWrite_M(memWrite_M), .memRead_M(memRead_M),
    .resultScr_M(resultScr_M), .alu_rsl_M(alu_rsl_M), .write_Data_M(write_Data_M),
    .rd_M(rd_M), .mode_M(mode_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .regWrite_W(regWrite_W), .resultScr_W(resultScr_W), .alu_rsl_W(alu_rsl_W),
    .read_data_W(read_data_W), .rd_W(rd_W), .stall_M(stall_M), .fault_M(fault_M)
  );

  always #5 clk = ~clk;

  typedef struct {logic rw; logic rs; logic [31:0] alu; logic [4:0] rd; logic [31:0] rdat;} wb_t;
  typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} rq_t;

  wb_t         wb_q[$];
  rq_t         rq_q[$];
  int          tests = 0, fails = 0;
  int          mem_wait = 0, mem_hold = 1, ack_left = 0, req_age = 0, req_count = 0;
  logic [31:0] mem_rdata = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_bytes(input logic [2:0] mode);
    case (mode % 4)
      0: return 1;
      1: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit ref_fault(input bit mr, input bit mw, input logic [2:0] mode, input logic [31:0] addr);
    bit legal;
    if (mr && mw) return 1'b1;
    if (!mr && !mw) return 1'b0;
    if (mr) legal = (mode == 0 || mode == 1 || mode == 2 || mode == 4 || mode == 5);
    else    legal = (mode == 0 || mode == 1 || mode == 2);
    if (!legal) return 1'b1;
    return (addr % acc_bytes(mode)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] v, b, h;
    v = rdata >> (8 * (addr % 4));
    b = v % 256;
    h = v % 65536;
    case (mode)
      0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      2: return v;
      4: return b;
      5: return h;
      default: return 32'h0;
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] data,
                           output logic [3:0] be, output logic [31:0] wd);
    case (mode)
      0: begin be = 4'(1 << (addr % 4)); wd = (data % 256) * 32'h01010101; end
      1: begin be = ((addr % 4) >= 2) ? 4'd12 : 4'd3; wd = (data % 65536) * 32'h00010001; end
      default: begin be = 4'd15; wd = data; end
    endcase
  endtask

  // ---------------- memory responder ----------------
  // Acks after mem_wait request cycles, holds ack mem_hold cycles, and only
  // raises a new ack after it has been low; rdata is junk except on a fresh ack.
  initial begin
    bit prev;
    forever begin
      @(negedge clk);
      prev = dmem_ack;
      if (!rst_n) begin
        ack_left = 0;
        req_age  = 0;
        dmem_ack = 1'b0;
      end else begin
        req_age = dmem_req ? req_age + 1 : 0;
        if (ack_left > 0) ack_left--;
        if (dmem_req && req_age > mem_wait && ack_left == 0 && !prev) begin
          ack_left   = mem_hold;
          dmem_rdata = mem_rdata;
        end else begin
          dmem_rdata = 32'hBAD0_0BAD;
        end
        dmem_ack = (ack_left > 0);
      end
    end
  end

  // ---------------- request monitor ----------------
  initial begin
    bit  prev_req;
    rq_t e;
    prev_req = 1'b0;
    e = '{1'b0, 32'h0, 4'h0, 32'h0};
    forever begin
      @(negedge clk);
      #2;
      if (dmem_req && !prev_req) begin
        req_count++;
        if (rq_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_req: got request addr=0x%08h we=%0b, expected no request", dmem_addr, dmem_we);
        end else begin
          e = rq_q.pop_front();
          chk("req_we", 32'(dmem_we), 32'(e.we));
          chk("req_addr", dmem_addr, e.addr);
          chk("req_be", 32'(dmem_be), 32'(e.be));
          chk("req_wdata", dmem_wdata, e.wdata);
        end
      end else if (dmem_req) begin
        chk("req_hold", {dmem_addr[31:2], dmem_be, dmem_we}, {e.addr[31:2], e.be, e.we});
      end
      prev_req = dmem_req;
    end
  end

  // ---------------- MEM/WB monitor ----------------
  initial begin
    bit  pend, bub;
    wb_t e;
    pend = 1'b0;
    bub  = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (pend && rst_n) begin
        if (wb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: got entry rd=%0d alu=0x%08h, expected none", rd_W, alu_rsl_W);
        end else begin
          e = wb_q.pop_front();
          chk("wb_regWrite", 32'(regWrite_W), 32'(e.rw));
          chk("wb_resultScr", 32'(resultScr_W), 32'(e.rs));
          chk("wb_alu", alu_rsl_W, e.alu);
          chk("wb_rd", 32'(rd_W), 32'(e.rd));
          chk("wb_read_data", read_data_W, e.rdat);
        end
      end else if (bub && rst_n) begin
        chk("wb_bubble", {28'h0, regWrite_W, resultScr_W, |rd_W, |alu_rsl_W} | read_data_W, 32'h0);
      end
      pend = rst_n && !stall_M;
      bub  = rst_n && stall_M;
    end
  end

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge after the instruction
  // has left MEM. chk_lat enables the latency/stall expectations.
  task automatic run(input bit rw, input bit mw, input bit mr, input bit rs,
                     input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                     input logic [2:0] mode, input logic [31:0] rdata,
                     input int wait_n, input int hold_n, input bit chk_lat, input string tag);
    bit          f, valid;
    logic [3:0]  sbe;
    logic [31:0] swd;
    int          stalls, faults, reqcyc, cyc, r0;
    f     = ref_fault(mr, mw, mode, alu);
    valid = (mr || mw) && !f;
    if (valid) begin
      ref_store(mode, alu, wd, sbe, swd);
      if (mw) rq_q.push_back('{1'b1, alu & 32'hFFFF_FFFC, sbe, swd});
      else    rq_q.push_back('{1'b0, alu & 32'hFFFF_FFFC, 4'hF, 32'h0});
    end
    wb_q.push_back('{rw && !f, rs, alu, rd, (mr && !f) ? ref_load(mode, alu, rdata) : 32'h0});
    mem_wait  = wait_n;
    mem_hold  = hold_n;
    mem_rdata = rdata;
    regWrite_M = rw; memWrite_M = mw; memRead_M = mr; resultScr_M = rs;
    alu_rsl_M = alu; write_Data_M = wd; rd_M = rd; mode_M = mode;
    r0 = req_count; stalls = 0; faults = 0; reqcyc = 0; cyc = 0;
    #1;
    forever begin
      if (fault_M) faults++;
      if (dmem_req) reqcyc++;
      if (!stall_M) break;
      stalls++;
      cyc++;
      if (cyc > 60) begin
        tests++;
        fails++;
        $display("FAIL %s_timeout: stall_M still 1 after %0d cycles, expected release", tag, cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "stall timeout");
      end
      @(negedge clk);
      #1;
    end
    chk({tag, "_fault"}, 32'(faults), 32'(f));
    chk({tag, "_reqs"}, 32'(req_count - r0), 32'(valid));
    if (chk_lat) begin
      chk({tag, "_stall"}, 32'(stalls), valid ? 32'(2 + wait_n) : 32'h0);
      chk({tag, "_reqcyc"}, 32'(reqcyc), valid ? 32'(1 + wait_n) : 32'h0);
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_dmem", {dmem_req, dmem_we, dmem_be, 26'h0} | dmem_addr | dmem_wdata, 32'h0);
    chk("rst_wb", {regWrite_W, resultScr_W, rd_W, 25'h0} | alu_rsl_W | read_data_W, 32'h0);
    chk("rst_hazard", {stall_M, fault_M}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // SW word store, zero-wait ack
    run(0, 1, 0, 0, 32'h100, 32'hDEADBEEF, 5'd0, 3'b010, 32'h0, 0, 1, 1, "sw");
    // SB to the top byte lane
    run(0, 1, 0, 0, 32'h103, 32'h000000A5, 5'd0, 3'b000, 32'h0, 0, 1, 1, "sb");
    // LB / LBU from the top lane
    run(1, 0, 1, 1, 32'h103, 32'h0, 5'd7, 3'b000, 32'h80FFFFFF, 0, 1, 1, "lb");
    run(1, 0, 1, 1, 32'h103, 32'h0, 5'd8, 3'b100, 32'h80FFFFFF, 0, 1, 1, "lbu");
    // LH upper half with three wait cycles
    run(1, 0, 1, 1, 32'h102, 32'h0, 5'd9, 3'b001, 32'h80011234, 3, 1, 1, "lh");
    // Faults: misaligned word, illegal load mode
    run(1, 0, 1, 1, 32'h101, 32'h0, 5'd10, 3'b010, 32'h0, 0, 1, 1, "lw_mis");
    run(1, 0, 1, 1, 32'h100, 32'h0, 5'd11, 3'b011, 32'h0, 0, 1, 1, "ld_ill");
    // Store with regWrite set propagates it
    run(1, 1, 0, 0, 32'h102, 32'h0000BEEF, 5'd12, 3'b001, 32'h0, 1, 1, 1, "sh_rw");

    // Reset dropped while a request is outstanding
    rq_q.push_back('{1'b1, 32'h300, 4'hF, 32'h12345678});
    mem_wait = 20;
    regWrite_M = 0; memWrite_M = 1; memRead_M = 0; resultScr_M = 0;
    alu_rsl_M = 32'h300; write_Data_M = 32'h12345678; rd_M = 0; mode_M = 3'b010;
    @(negedge clk);
    #3;
    chk("rstreq_req_before", 32'(dmem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstreq_dmem", {dmem_req, dmem_we, dmem_be, 26'h0} | dmem_addr | dmem_wdata, 32'h0);
    chk("rstreq_wb", {regWrite_W, resultScr_W, rd_W, 25'h0} | alu_rsl_W | read_data_W, 32'h0);
    chk("rstreq_hazard", {stall_M, fault_M}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(1, 0, 0, 0, 32'h2A, 32'h0, 5'd5, 3'b000, 32'h0, 0, 1, 1, "add");

    // Ack held four cycles, then a back-to-back load must wait for a fresh ack
    r0 = req_count;
    run(1, 0, 1, 0, 32'h200, 32'h0, 5'd13, 3'b010, 32'h11111111, 0, 4, 1, "lw_hold");
    run(1, 0, 1, 0, 32'h204, 32'h0, 5'd14, 3'b010, 32'h22222222, 0, 1, 0, "lw_b2b");
    chk("hold_total_reqs", 32'(req_count - r0), 32'h2);

    // Randomized mix
    for (int i = 0; i < 150; i++) begin
      int          kind;
      logic [31:0] a, d, rdat;
      logic [2:0]  m;
      bit          mw, mr;
      kind = $urandom_range(0, 9);
      a    = ($urandom & 32'h0000_FFF0) | 32'($urandom_range(0, 3));
      d    = $urandom;
      rdat = $urandom;
      m    = 3'($urandom_range(0, 7));
      mr   = (kind >= 3 && kind <= 5) || kind == 9;
      mw   = (kind >= 6);
      run(1'($urandom_range(0, 1)), mw, mr, 1'($urandom_range(0, 1)), a, d,
          5'($urandom_range(0, 31)), m, rdat, $urandom_range(0, 3), 1, 1, "rnd");
    end

    #5;
    chk("wb_queue_empty", 32'(wb_q.size()), 32'h0);
    chk("rq_queue_empty", 32'(rq_q.size()), 32'h0);
    finish_run();
  end

endmodule
